// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: access-size codes, FSM states, alignment check.
package dmem_responder_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_WAIT = 2'd1,
        DR_RESP = 2'd2
    } drState_e;

    // Size code 2'b11 behaves as a word access everywhere.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_B:  isMisaligned = 1'b0;
            SIZE_H:  isMisaligned = offset[0];
            default: isMisaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store data/byte-enables per lane and load extract with sign/zero extension.
module dmem_lane_align
    import dmem_responder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   wdata,
    input  logic [1:0]        storeSize,
    input  logic [1:0]        storeOff,
    output logic [XLEN-1:0]   storeData,
    output logic [XLEN/8-1:0] storeBe,
    input  logic [XLEN-1:0]   loadWord,
    input  logic [1:0]        loadSize,
    input  logic [1:0]        loadOff,
    input  logic              loadUnsigned,
    output logic [XLEN-1:0]   loadData
);

    // Store merge is expressed as replicated data plus byte enables so the array keeps a pure write port.
    for (genvar gi = 0; gi < XLEN / 8; gi++) begin : gLane
        assign storeData[gi*8 +: 8] = (storeSize == SIZE_B) ? wdata[7:0] :
                                      (storeSize == SIZE_H) ? wdata[(gi % 2)*8 +: 8] :
                                                              wdata[gi*8 +: 8];
        assign storeBe[gi] = (storeSize == SIZE_B) ? (storeOff == 2'(gi % 4)) :
                             (storeSize == SIZE_H) ? (storeOff[1] == 1'((gi / 2) % 2)) :
                                                     1'b1;
    end

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign byteSel = loadWord[{loadOff, 3'b000} +: 8];
    assign halfSel = loadWord[{loadOff[1], 4'b0000} +: 16];

    always_comb begin
        loadData = loadWord;
        case (loadSize)
            SIZE_B:  loadData = {{(XLEN-8){~loadUnsigned & byteSel[7]}}, byteSel};
            SIZE_H:  loadData = {{(XLEN-16){~loadUnsigned & halfSel[15]}}, halfSel};
            default: loadData = loadWord;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder with byte/half/word access over a valid/ready request port.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses and suppress their stores.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_SIZE   = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [ADDR_SIZE-1:0] req_pc,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LANES = XLEN / 8;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    drState_e stateReg, stateNext;
    logic [3:0] cntReg, cntNext;
    logic accept, enterResp;

    logic                 weReg;
    logic [1:0]           sizeReg;
    logic                 unsignedReg;
    logic [ADDR_SIZE-1:0] addrReg;
    logic [XLEN-1:0]      wdataReg;
    logic [ADDR_SIZE-1:0] pcReg;

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] rdWordReg;

    logic            respValidReg, respErrReg;
    logic [XLEN-1:0] respRdataReg;

    // With zero wait states the array is accessed on the accept edge, before the latches hold the request.
    logic                 curWe;
    logic [1:0]           curSize;
    logic [ADDR_SIZE-1:0] curAddr;
    logic [XLEN-1:0]      curWdata;
    logic [IDX_W-1:0]     curIdx;
    logic                 curMisaligned, latMisaligned;

    logic [XLEN-1:0]  storeData, loadData;
    logic [LANES-1:0] storeBe;

    assign curWe    = (stateReg == DR_IDLE) ? req_we    : weReg;
    assign curSize  = (stateReg == DR_IDLE) ? req_size  : sizeReg;
    assign curAddr  = (stateReg == DR_IDLE) ? req_addr  : addrReg;
    assign curWdata = (stateReg == DR_IDLE) ? req_wdata : wdataReg;
    assign curIdx   = curAddr[IDX_W+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign curMisaligned = isMisaligned(curSize, curAddr[1:0]);
    assign latMisaligned = isMisaligned(sizeReg, addrReg[1:0]);
`else
    assign curMisaligned = 1'b0;
    assign latMisaligned = 1'b0;
`endif

    dmem_lane_align #(.XLEN(XLEN)) uLaneAlign (
        .wdata        (curWdata),
        .storeSize    (curSize),
        .storeOff     (curAddr[1:0]),
        .storeData    (storeData),
        .storeBe      (storeBe),
        .loadWord     (rdWordReg),
        .loadSize     (sizeReg),
        .loadOff      (addrReg[1:0]),
        .loadUnsigned (unsignedReg),
        .loadData     (loadData)
    );

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        accept    = 1'b0;
        enterResp = 1'b0;
        case (stateReg)
            DR_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        stateNext = DR_RESP;
                        enterResp = 1'b1;
                    end else begin
                        stateNext = DR_WAIT;
                        cntNext   = CNT_INIT;
                    end
                end
            end
            DR_WAIT: begin
                if (cntReg == 4'd0) begin
                    stateNext = DR_RESP;
                    enterResp = 1'b1;
                end else begin
                    cntNext = cntReg - 4'd1;
                end
            end
            DR_RESP: stateNext = DR_IDLE;
            default: stateNext = DR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= DR_IDLE;
            cntReg       <= 4'd0;
            respValidReg <= 1'b0;
            respRdataReg <= '0;
            respErrReg   <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            cntReg       <= cntNext;
            respValidReg <= (stateReg == DR_RESP);
            respErrReg   <= (stateReg == DR_RESP) && latMisaligned;
            if (stateReg == DR_RESP) begin
                respRdataReg <= (weReg || latMisaligned) ? '0 : loadData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            weReg       <= req_we;
            sizeReg     <= req_size;
            unsignedReg <= req_unsigned;
            addrReg     <= req_addr;
            wdataReg    <= req_wdata;
            pcReg       <= req_pc;
        end
    end

    // Reset gating keeps an aborted store from ever reaching the array.
    always_ff @(posedge clk) begin
        if (!reset && enterResp) begin
            if (curWe) begin
                if (!curMisaligned) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (storeBe[i]) mem[curIdx][i*8 +: 8] <= storeData[i*8 +: 8];
                    end
                end
            end else begin
                rdWordReg <= mem[curIdx];
            end
        end
    end

    assign req_ready  = (stateReg == DR_IDLE);
    assign resp_valid = respValidReg;
    assign resp_rdata = respRdataReg;
    assign resp_err   = respErrReg;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    dmem_responder #(.XLEN(32), .ADDR_SIZE(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mb [4096];
    int          cyc = 0;
    int          lastAcc = -1000;
    bit          heldValid = 0;
    bit          started = 0;
    logic [31:0] lastRdata = '0;
    int          passCnt = 0;
    int          checkCnt = 0;
    int          respNum = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit modelMisaligned(input logic [1:0] sz, input logic [31:0] addr);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (sz == 2'b01 && addr % 2 != 0) || (sz >= 2'b10 && addr % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] sz, input bit uns, input logic [31:0] addr);
        int a;
        logic [31:0] v;
        a = int'(addr % 4096);
        case (sz)
            2'b00: begin
                v = {24'h0, mb[a]};
                if (!uns && v[7]) v[31:8] = '1;
            end
            2'b01: begin
                a = a - a % 2;
                v = {16'h0, mb[a+1], mb[a]};
                if (!uns && v[15]) v[31:16] = '1;
            end
            default: begin
                a = a - a % 4;
                v = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
            end
        endcase
        return v;
    endfunction

    task automatic modelStore(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        int a;
        a = int'(addr % 4096);
        case (sz)
            2'b00: mb[a] = wd[7:0];
            2'b01: begin
                a = a - a % 2;
                mb[a] = wd[7:0]; mb[a+1] = wd[15:8];
            end
            default: begin
                a = a - a % 4;
                for (int i = 0; i < 4; i++) mb[a+i] = wd[i*8 +: 8];
            end
        endcase
    endtask

    // Leaves req_valid high so a following call exercises back-to-back acceptance.
    task automatic doReq(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                         input logic [31:0] wd, input bit abort);
        bit acc;
        int tries;
        exp_t e;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_pc = $urandom;
        acc = 0;
        tries = 0;
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #2;
            tries++;
        end
        if (!acc) begin
            checkCnt++;
            $display("FAIL accept_timeout: no accept within %0d cycles, addr %h", tries, addr);
            req_valid = 1'b0;
            heldValid = 0;
            return;
        end
        if (heldValid) chk("accept_spacing", 32'(cyc - lastAcc), 32'(WAITC + 2));
        if (abort) begin
            reset = 1'b1; req_valid = 1'b0;
            lastAcc = -1000; heldValid = 0; lastRdata = '0;
            @(posedge clk);
            #2;
            reset = 1'b0;
            return;
        end
        e.err = modelMisaligned(sz, addr);
        e.rdata = (we || e.err) ? 32'h0 : modelLoad(sz, uns, addr);
        e.acc = cyc;
        q.push_back(e);
        if (we && !e.err) modelStore(sz, addr, wd);
        lastAcc = cyc;
        heldValid = 1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        heldValid = 0;
        for (int i = 0; i < n; i++) begin
            req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            @(posedge clk);
            #2;
        end
    endtask

    always @(negedge clk) begin
        if (started && !reset) begin
            chk("req_ready", {31'h0, req_ready}, {31'h0, (cyc > lastAcc + WAITC)});
            if (resp_valid) begin
                if (q.size() == 0) begin
                    checkCnt++;
                    $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding, rdata %h", resp_rdata);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    respNum++;
                    $display("resp %0d: rdata=%h err=%b latency=%0d", respNum, resp_rdata, resp_err, cyc - e.acc);
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                    chk("resp_latency", 32'(cyc - e.acc), 32'(WAITC + 1));
                    lastRdata = e.rdata;
                end
            end else begin
                chk("rdata_hold", resp_rdata, lastRdata);
                chk("err_idle", {31'h0, resp_err}, 32'h0);
                if (q.size() > 0 && cyc > q[0].acc + WAITC + 1) begin
                    checkCnt++;
                    $display("FAIL missing_resp: no response by cycle %0d for accept at %0d", cyc, q[0].acc);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset_rdata", resp_rdata, 32'h0);
        chk("reset_err", {31'h0, resp_err}, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        started = 1;

        // Give every word a known value so random loads have defined expectations.
        for (int w = 0; w < 1024; w++) doReq(1, 2'b10, 0, 32'(w * 4), $urandom, 0);
        idle(2);

        doReq(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0); idle(1);
        doReq(0, 2'b10, 0, 32'h10, 32'h0, 0);         idle(1);
        doReq(1, 2'b00, 0, 32'h13, 32'h00000080, 0); idle(1);
        doReq(0, 2'b00, 0, 32'h13, 32'h0, 0);         idle(1);
        doReq(0, 2'b00, 1, 32'h13, 32'h0, 0);         idle(1);
        doReq(0, 2'b10, 0, 32'h10, 32'h0, 0);         idle(1);
        doReq(1, 2'b10, 0, 32'h14, 32'hCAFEF00D, 0);
        doReq(0, 2'b01, 0, 32'h16, 32'h0, 0);
        doReq(0, 2'b01, 1, 32'h14, 32'h0, 0);         idle(1);
        doReq(1, 2'b10, 0, 32'h20, 32'h12345678, 1);  idle(1);
        doReq(0, 2'b10, 0, 32'h20, 32'h0, 0);         idle(1);
        doReq(1, 2'b10, 0, 32'h1004, 32'h5A5AA5A5, 0); idle(1);
        doReq(0, 2'b10, 0, 32'h0004, 32'h0, 0);        idle(1);
        doReq(1, 2'b01, 0, 32'h21, 32'h0000A5C3, 0);  idle(1);
        doReq(0, 2'b10, 0, 32'h20, 32'h0, 0);         idle(1);
        doReq(0, 2'b11, 0, 32'h23, 32'h0, 0);         idle(1);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = ($urandom % 2 == 0) ? ($urandom % 128) : $urandom;
            if ($urandom % 3 == 0) idle($urandom % 3);
            doReq(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 0);
        end
        idle(1);

        for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
        if (q.size() > 0) begin
            checkCnt++;
            $display("FAIL drain: %0d responses still outstanding", q.size());
        end
        idle(2);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
